// File: rtl/decode_sb_stage.sv
// RV32I decode stage: register file with write-back bypass, per-register pending-write scoreboard
// and one registered output slot. Optional perf counters are built when DECODE_SB_PERF_EN is defined.
module decode_sb_stage #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NUM_WB   = 2,
    parameter int SB_CNT_W = 2,
    localparam int RW      = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [XLEN-1:0]        in_pc,
    input  logic                   flush,
    input  logic [NUM_WB-1:0]      wb_we,
    input  logic [NUM_WB*RW-1:0]   wb_rd_s,
    input  logic [NUM_WB*XLEN-1:0] wb_rd_v,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_inst,
    output logic [XLEN-1:0]        out_pc,
    output logic [RW-1:0]          out_rs1_s,
    output logic [RW-1:0]          out_rs2_s,
    output logic [RW-1:0]          out_rd_s,
    output logic [XLEN-1:0]        out_rs1_v,
    output logic [XLEN-1:0]        out_rs2_v,
    output logic [XLEN-1:0]        out_imm,
    output logic                   out_regf_we,
    output logic [31:0]            perf_hazard_cnt,
    output logic [31:0]            perf_bp_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [6:0]          opcode;
    logic [RW-1:0]       rs1_s, rs2_s, rd_s;
    logic [31:0]         imm32;
    logic [XLEN-1:0]     imm;
    logic                uses_rs1, uses_rs2, writes_rd;
    logic [RW-1:0]       wb_rd  [NUM_WB];
    logic [XLEN-1:0]     wb_v   [NUM_WB];
    logic [XLEN-1:0]     regs   [NREGS];
    logic [SB_CNT_W-1:0] pend   [NREGS];
    logic [SB_CNT_W-1:0] pend_nxt [NREGS];
    logic [XLEN-1:0]     rs1_v, rs2_v;
    logic                rs1_hit, rs2_hit;
    logic                raw1, raw2, waw, hazard, fire, underflow;

    for (genvar k = 0; k < NUM_WB; k++) begin : g_wb
        assign wb_rd[k] = wb_rd_s[k*RW +: RW];
        assign wb_v[k]  = wb_rd_v[k*XLEN +: XLEN];
    end

    assign opcode = in_inst[6:0];
    assign rd_s   = in_inst[7 +: RW];
    assign rs1_s  = in_inst[15 +: RW];
    assign rs2_s  = in_inst[20 +: RW];

    always_comb begin
        imm32     = '0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                imm32     = {in_inst[31:12], 12'b0};
                writes_rd = 1'b1;
            end
            OP_JAL: begin
                imm32     = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
                writes_rd = 1'b1;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                imm32     = {{20{in_inst[31]}}, in_inst[31:20]};
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_BRANCH: begin
                imm32    = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_STORE: begin
                imm32    = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_REG: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            default: ;
        endcase
        if (rd_s == '0) writes_rd = 1'b0;
    end

    assign imm = XLEN'($signed(imm32));

    // Operand read: ascending port loop so the highest-index matching write-back wins.
    always_comb begin
        rs1_v   = regs[rs1_s];
        rs2_v   = regs[rs2_s];
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_we[k] && wb_rd[k] != '0) begin
                if (wb_rd[k] == rs1_s) begin
                    rs1_v   = wb_v[k];
                    rs1_hit = 1'b1;
                end
                if (wb_rd[k] == rs2_s) begin
                    rs2_v   = wb_v[k];
                    rs2_hit = 1'b1;
                end
            end
        end
        if (rs1_s == '0) rs1_v = '0;
        if (rs2_s == '0) rs2_v = '0;
    end

    // A single pending writer retiring this very cycle is covered by the bypass, so no stall.
    assign raw1 = uses_rs1 && rs1_s != '0 &&
                  !(pend[rs1_s] == '0 || (pend[rs1_s] == SB_CNT_W'(1) && rs1_hit));
    assign raw2 = uses_rs2 && rs2_s != '0 &&
                  !(pend[rs2_s] == '0 || (pend[rs2_s] == SB_CNT_W'(1) && rs2_hit));
    assign waw    = writes_rd && (&pend[rd_s]);
    assign hazard = raw1 | raw2 | waw;

    // Handshake: an input beat transfers when in_valid & in_ready; an output beat leaves when
    // out_valid & out_ready, and all out_* are held while out_valid & !out_ready.
    assign in_ready = rst_n & (!out_valid | out_ready) & !hazard & !flush;
    assign fire     = in_valid & in_ready;

    always_comb begin
        int cnt;
        underflow = 1'b0;
        cnt       = 0;
        for (int r = 0; r < NREGS; r++) begin
            cnt = int'(pend[r]);
            if (fire && writes_rd && rd_s == RW'(r)) cnt = cnt + 1;
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_we[k] && wb_rd[k] == RW'(r) && r != 0) cnt = cnt - 1;
            end
            if (cnt < 0) begin
                underflow = 1'b1;
                cnt       = 0;
            end
            pend_nxt[r] = SB_CNT_W'(cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) pend[r] <= '0;
        end else if (flush) begin
            for (int r = 0; r < NREGS; r++) pend[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) pend[r] <= pend_nxt[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_we[k] && wb_rd[k] != '0) regs[wb_rd[k]] <= wb_v[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_inst    <= '0;
            out_pc      <= '0;
            out_rs1_s   <= '0;
            out_rs2_s   <= '0;
            out_rd_s    <= '0;
            out_rs1_v   <= '0;
            out_rs2_v   <= '0;
            out_imm     <= '0;
            out_regf_we <= 1'b0;
        end else if (fire) begin
            out_inst    <= in_inst;
            out_pc      <= in_pc;
            out_rs1_s   <= rs1_s;
            out_rs2_s   <= rs2_s;
            out_rd_s    <= rd_s;
            out_rs1_v   <= rs1_v;
            out_rs2_v   <= rs2_v;
            out_imm     <= imm;
            out_regf_we <= writes_rd;
        end
    end

`ifdef DECODE_SB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hazard_cnt <= '0;
            perf_bp_cnt     <= '0;
        end else begin
            if (in_valid && hazard)     perf_hazard_cnt <= perf_hazard_cnt + 32'd1;
            if (out_valid && !out_ready) perf_bp_cnt    <= perf_bp_cnt + 32'd1;
        end
    end
`else
    assign perf_hazard_cnt = '0;
    assign perf_bp_cnt     = '0;
`endif

`ifndef SYNTHESIS
    // Retiring more writers than are pending means the write-back side broke protocol.
    always @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (!underflow) else $error("decode_sb_stage: scoreboard counter decremented below zero");
        end
    end
`endif

endmodule

// File: tb/tb_decode_sb_stage.sv
// Directed bench for decode_sb_stage: decode, bypass, scoreboard stalls, back-pressure, flush, reset.
// Perf counter checks follow DECODE_SB_PERF_EN.
module tb_decode_sb_stage;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic [1:0]      wb_we;
    logic [2*RW-1:0] wb_rd_s;
    logic [2*XLEN-1:0] wb_rd_v;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic [RW-1:0]   out_rs1_s, out_rs2_s, out_rd_s;
    logic [XLEN-1:0] out_rs1_v, out_rs2_v, out_imm;
    logic            out_regf_we;
    logic [31:0]     perf_hazard_cnt, perf_bp_cnt;

    int checks = 0;
    int errors = 0;

    decode_sb_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .flush(flush), .wb_we(wb_we), .wb_rd_s(wb_rd_s), .wb_rd_v(wb_rd_v),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_rs1_s(out_rs1_s), .out_rs2_s(out_rs2_s), .out_rd_s(out_rd_s),
        .out_rs1_v(out_rs1_v), .out_rs2_v(out_rs2_v), .out_imm(out_imm),
        .out_regf_we(out_regf_we), .perf_hazard_cnt(perf_hazard_cnt), .perf_bp_cnt(perf_bp_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        in_valid = v;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    task automatic drive_wb(input logic [1:0] we, input logic [4:0] rd0, input logic [31:0] v0,
                            input logic [4:0] rd1, input logic [31:0] v1);
        wb_we   = we;
        wb_rd_s = {rd1, rd0};
        wb_rd_v = {v1, v0};
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive_in(1'b0, 32'h0, 32'h0);
        drive_wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
        checks++; if (out_imm !== 32'h0 || out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_data got imm %0h pc %0h exp 0", out_imm, out_pc); end
        checks++; if (perf_bp_cnt !== 32'h0 || perf_hazard_cnt !== 32'h0) begin errors++; $display("FAIL reset_perf got %0d/%0d exp 0", perf_bp_cnt, perf_hazard_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        drive_in(1'b1, enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'h100);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready got %0b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_out_valid got %0b exp 1", out_valid); end
        checks++; if (out_imm !== 32'd5) begin errors++; $display("FAIL addi_imm got %0h exp 5", out_imm); end
        checks++; if (out_rd_s !== 5'd1 || out_regf_we !== 1'b1) begin errors++; $display("FAIL addi_rd got %0d we %0b exp 1 1", out_rd_s, out_regf_we); end
        checks++; if (out_pc !== 32'h100 || out_rs1_v !== 32'h0) begin errors++; $display("FAIL addi_pc_rs1 got %0h %0h exp 100 0", out_pc, out_rs1_v); end
    endtask

    task automatic test_raw_bypass();
        drive_in(1'b1, enc_add(5'd2, 5'd1, 5'd1), 32'h104);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got %0b exp 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_drain got %0b exp 0", out_valid); end
        drive_wb(2'b01, 5'd1, 32'd5, 5'd0, 32'd0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_release got %0b exp 1", in_ready); end
        tick();
        drive_wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        checks++; if (out_valid !== 1'b1 || out_rd_s !== 5'd2) begin errors++; $display("FAIL raw_issue got v %0b rd %0d exp 1 2", out_valid, out_rd_s); end
        checks++; if (out_rs1_v !== 32'd5 || out_rs2_v !== 32'd5) begin errors++; $display("FAIL raw_bypass got %0h %0h exp 5 5", out_rs1_v, out_rs2_v); end
    endtask

    task automatic test_multi_wb();
        drive_in(1'b1, enc_i(12'd1, 5'd0, 3'b000, 5'd3, 7'b0010011), 32'h108);
        tick();
        // lw x3,0(x3) with both ports retiring x3 in the same cycle
        drive_in(1'b1, enc_i(12'd0, 5'd3, 3'b010, 5'd3, 7'b0000011), 32'h10c);
        drive_wb(2'b11, 5'd3, 32'd7, 5'd3, 32'd9);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mwb_ready got %0b exp 1", in_ready); end
        tick();
        drive_wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        checks++; if (out_rs1_v !== 32'd9) begin errors++; $display("FAIL mwb_bypass got %0h exp 9", out_rs1_v); end
        checks++; if (out_pc !== 32'h10c || out_imm !== 32'h0) begin errors++; $display("FAIL mwb_lw got pc %0h imm %0h exp 10c 0", out_pc, out_imm); end
        drive_in(1'b1, enc_i(12'd0, 5'd3, 3'b000, 5'd8, 7'b0010011), 32'h110);
        tick();
        checks++; if (out_rs1_v !== 32'd9 || out_pc !== 32'h110) begin errors++; $display("FAIL mwb_regfile got %0h pc %0h exp 9 110", out_rs1_v, out_pc); end
    endtask

    task automatic test_decode_imm();
        logic [31:0] insts [6];
        logic [31:0] imms  [6];
        logic        wes   [6];
        insts[0] = {20'h12345, 5'd11, 7'b0110111};                                     imms[0] = 32'h12345000; wes[0] = 1'b1;
        insts[1] = enc_i(12'hffd, 5'd0, 3'b000, 5'd12, 7'b0010011);                     imms[1] = 32'hfffffffd; wes[1] = 1'b1;
        insts[2] = {1'b1, 6'b111111, 5'd0, 5'd0, 3'b000, 4'b1100, 1'b1, 7'b1100011};  imms[2] = 32'hfffffff8; wes[2] = 1'b0;
        insts[3] = {1'b0, 10'b0, 1'b1, 8'b0, 5'd13, 7'b1101111};                        imms[3] = 32'h00000800; wes[3] = 1'b1;
        insts[4] = 32'hffffffff;                                                        imms[4] = 32'h0;        wes[4] = 1'b0;
        insts[5] = enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011);                        imms[5] = 32'd7;        wes[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_in(1'b1, insts[i], 32'h180 + 32'(i * 4));
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dec_ready[%0d] got %0b exp 1", i, in_ready); end
            tick();
            checks++; if (out_imm !== imms[i] || out_regf_we !== wes[i]) begin errors++; $display("FAIL dec_imm[%0d] got %0h we %0b exp %0h %0b", i, out_imm, out_regf_we, imms[i], wes[i]); end
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h180 + 32'(i * 4)) begin errors++; $display("FAIL dec_b2b[%0d] got v %0b pc %0h", i, out_valid, out_pc); end
        end
        drive_in(1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_backpressure();
        drive_in(1'b1, {7'b0, 5'd3, 5'd0, 3'b010, 5'd4, 7'b0100011}, 32'h200);
        tick();
        drive_in(1'b1, enc_i(12'd1, 5'd0, 3'b000, 5'd9, 7'b0010011), 32'h204);
        out_ready = 1'b0;
        checks++; if (out_imm !== 32'd4 || out_rs2_v !== 32'd9 || out_regf_we !== 1'b0) begin errors++; $display("FAIL bp_sw got imm %0h rs2 %0h we %0b exp 4 9 0", out_imm, out_rs2_v, out_regf_we); end
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %0b exp 0", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_imm !== 32'd4 || out_rs2_v !== 32'd9) begin errors++; $display("FAIL bp_hold[%0d] got v %0b pc %0h imm %0h", i, out_valid, out_pc, out_imm); end
        end
        out_ready = 1'b1;
`ifdef DECODE_SB_PERF_EN
        checks++; if (perf_bp_cnt !== 32'd4) begin errors++; $display("FAIL bp_perf got %0d exp 4", perf_bp_cnt); end
`else
        checks++; if (perf_bp_cnt !== 32'd0) begin errors++; $display("FAIL bp_perf got %0d exp 0", perf_bp_cnt); end
`endif
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %0b exp 1", in_ready); end
        tick();
        checks++; if (out_pc !== 32'h204 || out_imm !== 32'd1) begin errors++; $display("FAIL bp_next got pc %0h imm %0h exp 204 1", out_pc, out_imm); end
    endtask

    task automatic test_waw();
        for (int i = 0; i < 3; i++) begin
            drive_in(1'b1, enc_i(12'd1, 5'd0, 3'b000, 5'd4, 7'b0010011), 32'h300 + 32'(i * 4));
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL waw_fill[%0d] got %0b exp 1", i, in_ready); end
            tick();
        end
        drive_in(1'b1, enc_i(12'd4, 5'd0, 3'b000, 5'd4, 7'b0010011), 32'h30c);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_stall got %0b exp 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_stall2 got %0b exp 0", in_ready); end
        drive_wb(2'b01, 5'd4, 32'd1, 5'd0, 32'd0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_retire_cycle got %0b exp 0", in_ready); end
        tick();
        drive_wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL waw_release got %0b exp 1", in_ready); end
        tick();
        checks++; if (out_pc !== 32'h30c || out_imm !== 32'd4) begin errors++; $display("FAIL waw_issue got pc %0h imm %0h exp 30c 4", out_pc, out_imm); end
    endtask

    task automatic test_flush();
        drive_in(1'b1, enc_i(12'd1, 5'd0, 3'b000, 5'd5, 7'b0010011), 32'h400);
        tick();
        drive_in(1'b1, enc_i(12'd2, 5'd0, 3'b000, 5'd5, 7'b0010011), 32'h404);
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h404) begin errors++; $display("FAIL flush_setup got v %0b pc %0h", out_valid, out_pc); end
        out_ready = 1'b0;
        flush = 1'b1;
        drive_in(1'b1, enc_add(5'd6, 5'd5, 5'd5), 32'h408);
        drive_wb(2'b01, 5'd5, 32'd77, 5'd0, 32'd0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b exp 0", in_ready); end
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        drive_wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill got %0b exp 0", out_valid); end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_sb_clear got %0b exp 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h408) begin errors++; $display("FAIL flush_issue got v %0b pc %0h exp 1 408", out_valid, out_pc); end
        checks++; if (out_rs1_v !== 32'd77 || out_rs2_v !== 32'd77) begin errors++; $display("FAIL flush_wb got %0h %0h exp 4d 4d", out_rs1_v, out_rs2_v); end
`ifdef DECODE_SB_PERF_EN
        checks++; if (perf_bp_cnt !== 32'd5) begin errors++; $display("FAIL flush_perf got %0d exp 5", perf_bp_cnt); end
`endif
        drive_in(1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid();
        drive_in(1'b1, enc_i(12'd1, 5'd0, 3'b000, 5'd14, 7'b0010011), 32'h500);
        tick();
        out_ready = 1'b0;
        drive_in(1'b0, 32'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rstmid got v %0b rdy %0b exp 0 0", out_valid, in_ready); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rstmid_pc got %0h exp 0", out_pc); end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        checks++; if (perf_bp_cnt !== 32'h0 || perf_hazard_cnt !== 32'h0) begin errors++; $display("FAIL rstmid_perf got %0d/%0d exp 0", perf_bp_cnt, perf_hazard_cnt); end
        tick();
        drive_in(1'b1, enc_i(12'd0, 5'd5, 3'b000, 5'd15, 7'b0010011), 32'h504);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %0b exp 1", in_ready); end
        tick();
        checks++; if (out_rs1_v !== 32'h0 || out_pc !== 32'h504) begin errors++; $display("FAIL rstmid_regfile got %0h pc %0h exp 0 504", out_rs1_v, out_pc); end
        drive_in(1'b0, 32'h0, 32'h0);
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_addi();
        test_raw_bypass();
        test_multi_wb();
        test_decode_imm();
        test_backpressure();
        test_waw();
        test_flush();
        test_reset_mid();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
